// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: word/address widths, fetch FSM states and the
// queue entry layout (address + instruction word).
package cpu_pkg;

    localparam int WIDTH    = 32;
    localparam int ADDRSIZE = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDRSIZE-1:0] pc;
        logic [WIDTH-1:0]    data;
    } ins_entry_t;

endpackage

// File: rtl/ins_fifo.sv
// DEPTH-entry instruction queue with synchronous clear; the head output holds
// the last presented entry while the queue is empty.
module ins_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_clear,
    input  ins_entry_t    i_din,
    output ins_entry_t    o_head,
    output logic [CW-1:0] o_count
);

    ins_entry_t    r_mem [DEPTH];
    ins_entry_t    r_last;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_empty;
    logic          w_pop;

    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop & ~w_empty;
    assign o_head  = w_empty ? r_last : r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last   <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (!w_empty) begin
                r_last <= r_mem[r_rd_ptr];
            end
            if (i_clear) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (i_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (i_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!i_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(i_push && !w_pop && !i_clear && r_count == CW'(DEPTH)))
                else $error("ins_fifo: push into full queue");
        end
    end
`endif

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch stage: walks the fetch PC ahead of the core, buffers
// fetched words in ins_fifo, and flushes on branch redirect.
//
// state | meaning
// IDLE  | first cycle after reset, no fetch
// FETCH | issuing sequential fetches while the queue has room
// HALT  | fetching stopped, queue drains to the core
module inst_prefetch_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_imem_req,
    output logic [ADDRSIZE-1:0] o_imem_addr,
    input  logic [WIDTH-1:0]    i_imem_data,
    output logic                o_ins_valid,
    output logic [WIDTH-1:0]    o_ins_data,
    output logic [ADDRSIZE-1:0] o_ins_pc,
    input  logic                i_ins_ready,
    input  logic                i_redirect,
    input  logic [ADDRSIZE-1:0] i_redirect_addr,
    input  logic                i_halt,
    output logic [CW-1:0]       o_count
);

    fetch_state_t        r_state;
    logic [ADDRSIZE-1:0] r_pc;
    logic [ADDRSIZE-1:0] r_req_pc;
    logic                r_inflight;
    logic                w_req;
    logic                w_push;
    logic                w_pop;
    logic [CW:0]         w_occ;
    logic [CW-1:0]       w_count;
    ins_entry_t          w_din;
    ins_entry_t          w_head;

    // Occupancy includes the outstanding response so the queue can never overflow.
    assign w_occ  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_req  = (r_state == FETCH) & ~i_halt & ~i_redirect & (w_occ < (CW+1)'(DEPTH));
    assign w_push = r_inflight & ~i_redirect;
    assign w_pop  = o_ins_valid & i_ins_ready;
    assign w_din  = {r_req_pc, i_imem_data};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            case (r_state)
                IDLE:    r_state <= FETCH;
                FETCH:   if (i_halt) r_state <= HALT;
                HALT:    if (!i_halt) r_state <= FETCH;
                default: r_state <= IDLE;
            endcase
            if (i_redirect) begin
                r_pc <= i_redirect_addr;
            end else if (w_req) begin
                r_pc     <= r_pc + ADDRSIZE'(1);
                r_req_pc <= r_pc;
            end
        end
    end

    ins_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (i_redirect),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_ins_valid = (w_count != '0);
    assign o_ins_data  = w_head.data;
    assign o_ins_pc    = w_head.pc;
    assign o_count     = w_count;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed timing checks plus random traffic,
// with delivered words scored against the expected sequential fetch stream.
module tb_inst_prefetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                imem_req;
    logic [ADDRSIZE-1:0] imem_addr;
    logic [WIDTH-1:0]    imem_data;
    logic                ins_valid;
    logic [WIDTH-1:0]    ins_data;
    logic [ADDRSIZE-1:0] ins_pc;
    logic                ins_ready;
    logic                redirect;
    logic [ADDRSIZE-1:0] redirect_addr;
    logic                halt;
    logic [CW-1:0]       count;

    int n_vec  = 0;
    int n_err  = 0;
    int n_xfer = 0;
    int gen_pc = 0;
    logic [ADDRSIZE-1:0] exp_q[$];
    logic [ADDRSIZE-1:0] mon_pc;

    inst_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_data     (imem_data),
        .o_ins_valid     (ins_valid),
        .o_ins_data      (ins_data),
        .o_ins_pc        (ins_pc),
        .i_ins_ready     (ins_ready),
        .i_redirect      (redirect),
        .i_redirect_addr (redirect_addr),
        .i_halt          (halt),
        .o_count         (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [ADDRSIZE-1:0] a);
        return 32'(a) + 32'd100;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(ADDRSIZE'(gen_pc));
            gen_pc = (gen_pc + 1) % (1 << ADDRSIZE);
        end
    endtask

    task automatic restart(input int target);
        exp_q.delete();
        gen_pc = target;
        refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req"},   32'(imem_req),  0);
        chk({tag, "_addr"},  32'(imem_addr), 0);
        chk({tag, "_valid"}, 32'(ins_valid), 0);
        chk({tag, "_data"},  ins_data,       0);
        chk({tag, "_pc"},    32'(ins_pc),    0);
        chk({tag, "_count"}, 32'(count),     0);
    endtask

    // Instruction memory: returns the word for the address requested last cycle.
    initial begin
        logic                p_req;
        logic [ADDRSIZE-1:0] p_addr;
        imem_data = '0;
        forever begin
            @(negedge clk);
            p_req  = imem_req;
            p_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_data = p_req ? word(p_addr) : $urandom;
        end
    end

    // Scoreboard monitor: every accepted head must be the next expected word.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count_bound", 32'(count <= CW'(DEPTH)), 1);
            if (ins_valid && ins_ready && !redirect) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty: got pc 0x%0h, want no transfer", ins_pc);
                end else begin
                    mon_pc = exp_q.pop_front();
                    chk("sb_pc",   32'(ins_pc), 32'(mon_pc));
                    chk("sb_data", ins_data,    word(mon_pc));
                end
            end
        end
    end

    initial begin
        int xb;
        ins_ready     = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        halt          = 1'b0;
        restart(0);

        #2;
        chk_zero_outputs("rst");

        // release between edges: cycle 1 idle, req cycle 2, valid cycle 4
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ins_ready = 1'b1;
        restart(0);
        tick();
        chk("c2_req",   32'(imem_req),  1);
        chk("c2_addr",  32'(imem_addr), 0);
        chk("c2_valid", 32'(ins_valid), 0);
        tick();
        chk("c3_valid", 32'(ins_valid), 0);
        tick();
        chk("c4_valid", 32'(ins_valid), 1);
        chk("c4_pc",    32'(ins_pc),    0);
        chk("c4_data",  ins_data,       100);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stream_valid", 32'(ins_valid), 1);
            chk("stream_cnt_le2", 32'(count <= CW'(2)), 1);
        end

        // back-pressure fills the queue
        ins_ready = 1'b0;
        repeat (10) tick();
        chk("full_count", 32'(count),    4);
        chk("full_req",   32'(imem_req), 0);
        ins_ready = 1'b1;
        xb = n_xfer;
        repeat (4) tick();
        chk("drain4_xfers", 32'(n_xfer - xb), 4);

        // redirect with three queued words and a response in flight
        ins_ready = 1'b0;
        for (int i = 0; i < 20 && count != CW'(3); i++) tick();
        chk("wait_cnt3", 32'(count), 3);
        redirect      = 1'b1;
        redirect_addr = 12'h200;
        ins_ready     = 1'b1;
        restart(12'h200);
        tick();
        redirect = 1'b0;
        #1;
        chk("r1_valid", 32'(ins_valid), 0);
        chk("r1_count", 32'(count),     0);
        chk("r1_req",   32'(imem_req),  1);
        chk("r1_addr",  32'(imem_addr), 32'h200);
        tick();
        chk("r2_valid", 32'(ins_valid), 0);
        tick();
        chk("r3_valid", 32'(ins_valid), 1);
        chk("r3_pc",    32'(ins_pc),    32'h200);

        // address wrap at the top of memory
        redirect      = 1'b1;
        redirect_addr = 12'd4094;
        restart(4094);
        tick();
        redirect = 1'b0;
        #1;
        tick();
        tick();
        chk("wrap_pc0", 32'(ins_pc), 4094);
        tick();
        chk("wrap_pc1", 32'(ins_pc), 4095);
        tick();
        chk("wrap_pc2", 32'(ins_pc), 0);
        tick();
        chk("wrap_pc3", 32'(ins_pc), 1);

        // halt with one queued word and one in flight
        repeat (3) tick();
        chk("pre_halt_count", 32'(count), 1);
        halt      = 1'b1;
        ins_ready = 1'b0;
        #1;
        chk("halt_req0", 32'(imem_req), 0);
        tick();
        chk("halt_count2", 32'(count),    2);
        chk("halt_req1",   32'(imem_req), 0);
        ins_ready = 1'b1;
        tick();
        tick();
        chk("halt_drained", 32'(count),     0);
        chk("halt_valid",   32'(ins_valid), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_noreq", 32'(imem_req), 0);
        end
        halt = 1'b0;
        #1;
        chk("resume_req0", 32'(imem_req), 0);
        tick();
        chk("resume_req",  32'(imem_req),  1);
        chk("resume_addr", 32'(imem_addr), 32'(exp_q[0]));

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            ins_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect      = 1'b1;
                redirect_addr = ADDRSIZE'($urandom);
                restart(int'(redirect_addr));
            end else begin
                redirect = 1'b0;
            end
            if ($urandom_range(0, 49) == 0) halt = ~halt;
            tick();
        end
        redirect = 1'b0;
        halt     = 1'b0;
        ins_ready = 1'b1;
        repeat (5) tick();

        // asynchronous reset pulse between edges
        #3;
        rst = 1'b1;
        #1;
        chk_zero_outputs("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        restart(0);
        tick();
        chk("arst_c2_req",  32'(imem_req),  1);
        chk("arst_c2_addr", 32'(imem_addr), 0);
        tick();
        chk("arst_c3_valid", 32'(ins_valid), 0);
        tick();
        chk("arst_c4_valid", 32'(ins_valid), 1);
        chk("arst_c4_pc",    32'(ins_pc),    0);
        chk("arst_c4_data",  ins_data,       100);
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Instruction prefetch stage between the instruction memory and the CPU core. It walks a fetch PC through instruction memory ahead of execution, buffers up to DEPTH fetched words with their addresses, and presents them to the core over a valid/ready handshake. It also handles branch redirects by flushing buffered and in-flight words, and halts fetching on request.

## Interface
- WIDTH, 32, instruction word width
- ADDRSIZE, 12, instruction address width (4096-word space)
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDRSIZE  fetch address, equals fetch PC
- imem_data  in  WIDTH  word for the request of the previous cycle
- ins_valid  out  1  head entry valid
- ins_data  out  WIDTH  head instruction word
- ins_pc  out  ADDRSIZE  address of head word
- ins_ready  in  1  core accepts head this cycle
- redirect  in  1  branch taken; flush and refetch
- redirect_addr  in  ADDRSIZE  new fetch PC
- halt  in  1  stop issuing fetches
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Reset: pc=0, state=IDLE, queue empty, inflight=0; imem_req=0, imem_addr=0, ins_valid=0, ins_data=0, ins_pc=0, count=0. Takes effect immediately; any in-flight response is discarded.
- FSM:
  - IDLE goes to FETCH on the first clock after reset release.
  - FETCH goes to HALT when halt=1.
  - HALT goes to FETCH when halt=0.
  - Redirect is accepted in every state.
- Request: imem_req = (state==FETCH) & ~halt & ~redirect & (count + inflight < DEPTH).
  - inflight is a register that samples imem_req.
  - A pop in the same cycle is not credited.
  - When the request is issued, pc increments by 1 at the edge, wrapping 4095→0 (modulo 2^ADDRSIZE).
- Response: when inflight=1 and no kill condition, {pc of request, imem_data} is pushed at the end of that cycle.
  - The request PC is held in a one-entry register.
- Pop: ins_valid & ins_ready removes the head at the edge.
  - Push and pop in the same cycle are allowed, including when the queue is full or empty-plus-push.
  - A word pushed in cycle N is visible at the head no earlier than N+1; there is no bypass.
- Redirect (sampled high at an edge):
  - Queue cleared and count=0.
  - inflight response dropped: it arrives in the following cycle and is not pushed.
  - pc set to redirect_addr.
  - Redirect has priority over a same-cycle pop and push; the head shown in that cycle is discarded and counts as not transferred.
- Halt: no new requests. An in-flight response still pushes, and the queue drains normally. Deasserting halt resumes fetching from the held pc.
- Overflow is structurally impossible; an implementation must assert (sim only) that a push never occurs when count==DEPTH without a pop.
- ins_data and ins_pc are driven from the queue head. They hold the last head value when empty, with ins_valid=0.

## Timing
- Reset released before edge E0: IDLE during cycle 1, first request (addr 0) in cycle 2, data on imem_data in cycle 3, ins_valid=1 in cycle 4.
- Fetch-to-valid latency is 2 cycles (req N, valid N+2).
- Redirect sampled at end of cycle R:
  - Cycle R+1: ins_valid=0 and imem_req=1 with imem_addr=redirect_addr.
  - Cycle R+3: ins_valid=1 with ins_pc=redirect_addr.
- With ins_ready held at 1, throughput is 1 instruction per cycle in steady state. Occupancy settles ≤ 2 (DEPTH=4).
- Back-to-back redirects: each one restarts the R+1/R+3 sequence; only the last target is fetched.

## Structure
- Shared package cpu_pkg holds:
  - WIDTH and ADDRSIZE constants.
  - fetch_state_t enum {IDLE, FETCH, HALT}.
  - Packed ins_entry_t {pc, data}.
- Sub-module ins_fifo:
  - Synchronous DEPTH×(ADDRSIZE+WIDTH) FIFO with push, pop, clear, count, and head.
  - Pointers wrap modulo DEPTH.
  - clear has priority over push and pop.
- The top level holds the FSM, pc, inflight, request-PC register, and the kill logic.

## Test plan
- Reset then ins_ready=1, I_MEM[k]=k+100: ins_pc 0,1,2,… with ins_data 100,101,… on consecutive cycles from cycle 4; count never exceeds 2.
- ins_ready=0 for 10 cycles: count reaches 4 and holds; imem_req=0 while count+inflight=4; on release, 4 words pop in order with no loss or duplicate.
- Redirect to 0x200 while count=3 and a request is in flight: next cycle ins_valid=0, count=0, imem_addr=0x200; ins_pc=0x200 three cycles after redirect; the stale in-flight word never appears.
- pc at 4094, consumer ready: ins_pc sequence 4094, 4095, 0, 1.
- halt=1 with count=1, inflight=1: no further imem_req, count reaches 2 then drains to 0 with ready=1; halt=0 resumes at the next sequential address.
- Async rst pulse mid-stream, between clock edges: all outputs read 0 immediately; after release the sequence restarts from address 0 at cycle 4.
